alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (add/sub/or) among NUM_REQ requesters, e.g. a branch-compare unit, an address generator and a debug port.
- Arbitrates round-robin, drives the ALU operands and control code from registers, and captures the ALU result and Zero flag.
- Returns each result with the requester ID over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).
- DATA_W, 32, operand/result width; must match the ALU (32).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_op  input  NUM_REQ*4  per-requester ALU control code; slice i is [4i+3:4i].
- req_src0  input  NUM_REQ*DATA_W  per-requester operand 0.
- req_src1  input  NUM_REQ*DATA_W  per-requester operand 1.
- alu_control  output  4  to ALU ALU_control.
- alu_src0  output  DATA_W  to ALU src0.
- alu_src1  output  DATA_W  to ALU src1.
- alu_result  input  DATA_W  from ALU ALU_result.
- alu_zero  input  1  from ALU Zero.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester being answered.
- rsp_result  output  DATA_W  captured result.
- rsp_zero  output  1  captured Zero flag.
- rsp_err  output  1  illegal op code; no ALU operation performed.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - Issue registers: op=4'b0000, operands=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0.
  - alu_control=0, alu_src0=0, alu_src1=0, req_ready=0.
- Legal ops: 4'b0010 add, 4'b0110 sub, 4'b0001 or. All other codes are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: the first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant]=1 only in IDLE, and only when at least one valid is set. Otherwise req_ready is all zero.
  - At the clock edge with the grant, latch id, op, src0 and src1.
  - Legal op: go to EXEC. Illegal op: load rsp_err=1, rsp_result=0, rsp_zero=0 and go directly to RESP.
  - No valid: stay in IDLE.
- EXEC (exactly one cycle):
  - alu_control, alu_src0 and alu_src1 are driven from the issue registers.
  - At the edge, capture alu_result into rsp_result and alu_zero into rsp_zero; set rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_zero and rsp_err are held stable until rsp_ready=1 at a clock edge.
  - On handshake: rr_ptr = (granted id + 1) mod NUM_REQ, state=IDLE.
  - While in RESP, alu_control, alu_src0 and alu_src1 hold the last issued values.
- ALU outputs outside EXEC: they hold the last issued values. They are never left to float, so the ALU's hold-on-unknown-op behaviour cannot leak a stale result.
- Latency:
  - Request accepted at edge N gives rsp_valid high in the cycle after edge N+1 (legal op) or after edge N (illegal op).
  - Minimum issue interval is 3 cycles per legal op with rsp_ready tied high.
- Requester rules:
  - A requester holds valid, op and operands stable until its req_ready is seen high at an edge.
  - Deasserting valid before acceptance is allowed; it removes that requester from arbitration.
- Simultaneous events:
  - A new request arriving during EXEC or RESP waits; it is never dropped.
  - All NUM_REQ requesters valid: served in strict rotation starting at rr_ptr, with no starvation.
- Arithmetic: wrap-around of add/sub is the ALU's responsibility. The block passes operands and results unmodified at DATA_W bits.
- Reset mid-operation: any in-flight request is discarded with no response. The requester must re-present it.

Test Plan:
- Single add: req 1 valid, op=0010, src0=5, src1=7 -> req_ready[1] for one cycle; 2 cycles later rsp_valid, rsp_id=1, rsp_result=12, rsp_zero=0, rsp_err=0.
- Sub to zero: req 0, op=0110, src0=src1=32'h1234 -> rsp_result=0, rsp_zero=1. Then src0=0, src1=1 -> rsp_result=32'hFFFFFFFF, rsp_zero=0.
- Round-robin: all 4 valid continuously with rsp_ready=1 and distinct ops (or of 32'hF0 with 32'h0F, etc.) -> rsp_id sequence 0,1,2,3,0; each rsp_valid 3 cycles apart; results correct per requester.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid and all rsp fields stay constant, req_ready stays 0, busy=1. On release, one handshake occurs and the next grant follows in IDLE.
- Illegal op: op=4'b1111 from req 2 -> rsp_valid 1 cycle after acceptance, rsp_err=1, rsp_result=0, rsp_zero=0. alu_control never equals 4'b1111 at any cycle.
- Reset mid-operation: assert rst_n=0 during EXEC -> immediately (asynchronously) rsp_valid=0, busy=0, req_ready=0. After release, rr_ptr=0: grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one combinational ALU among NUM_REQ requesters
// and returns each result, tagged with the requester index, over a valid/ready channel.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*4-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_src0,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  output logic [3:0]                alu_control,
  output logic [DATA_W-1:0]         alu_src0,
  output logic [DATA_W-1:0]         alu_src1,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam logic [3:0]      OP_ADD    = 4'b0010;
  localparam logic [3:0]      OP_SUB    = 4'b0110;
  localparam logic [3:0]      OP_OR     = 4'b0001;
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   src0_q, src0_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;

  logic [3:0]          op_arr   [NUM_REQ];
  logic [DATA_W-1:0]   src0_arr [NUM_REQ];
  logic [DATA_W-1:0]   src1_arr [NUM_REQ];

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W:0]       idx_w;
  logic                grant_legal;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]   = req_op[4*gi +: 4];
      assign src0_arr[gi] = req_src0[DATA_W*gi +: DATA_W];
      assign src1_arr[gi] = req_src1[DATA_W*gi +: DATA_W];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_w       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_w >= NUM_REQ_W) begin
        idx_w = idx_w - NUM_REQ_W;
      end
      if (!grant_found && req_valid[idx_w[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx_w[ID_W-1:0];
      end
    end
  end

  assign grant_legal = (op_arr[grant_id] == OP_ADD) ||
                       (op_arr[grant_id] == OP_SUB) ||
                       (op_arr[grant_id] == OP_OR);

  // Gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    src0_d       = src0_q;
    src1_d       = src1_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          id_d = grant_id;
          // Illegal codes never reach the ALU issue registers.
          if (grant_legal) begin
            op_d    = op_arr[grant_id];
            src0_d  = src0_arr[grant_id];
            src1_d  = src1_arr[grant_id];
            state_d = EXEC;
          end else begin
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            state_d      = RESP;
          end
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_q         <= 4'b0000;
      src0_q       <= '0;
      src1_q       <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      src0_q       <= src0_d;
      src1_q       <= src1_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_control = op_q;
  assign alu_src0    = src0_q;
  assign alu_src1    = src1_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != IDLE);

endmodule
